// File: rtl/dualram_fifo_ctrl.sv
// FIFO controller that drives an external 16x8 asynchronous dual-port RAM.
// It keeps wrap-bit pointers, registers the RAM read data, and reports status and error pulses.
module dualram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_cs,
    output logic                  ram_rst,
    output logic                  ram_wr_enb,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_enb,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int PW = ADDR_WIDTH + 1;

    if (DEPTH != (2 ** ADDR_WIDTH)) begin : g_bad_depth
        $error("dualram_fifo_ctrl: DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
    logic                  pop_valid_q, pop_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full_s, empty_s;
    logic push_acc, pop_acc;

    // Status derived purely from the registered pointers.
    always_comb begin
        empty_s = (wr_ptr_q == rd_ptr_q);
        full_s  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    end

    // When full, only the pop is taken; when empty, only the push is taken.
    always_comb begin
        push_acc = push & ~full_s;
        pop_acc  = pop & ~empty_s;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PW'(push_acc);
        rd_ptr_d    = rd_ptr_q + PW'(pop_acc);
        pop_data_d  = pop_data_q;
        pop_valid_d = pop_acc;
        if (pop_acc) begin
            pop_data_d = ram_rd_data;
        end
        overflow_d  = push & ~push_acc;
        underflow_d = pop & ~pop_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // RAM strobes are gated by reset so the RAM never sees a stray access.
    always_comb begin
        ram_rst     = rst;
        ram_cs      = ~rst;
        ram_wr_enb  = push_acc & ~rst;
        ram_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
        ram_wr_data = push_data;
        ram_rd_enb  = pop_acc & ~rst;
        ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
    end

    always_comb begin
        pop_data  = pop_data_q;
        pop_valid = pop_valid_q;
        overflow  = overflow_q;
        underflow = underflow_q;
        full      = full_s;
        empty     = empty_s;
        count     = wr_ptr_q - rd_ptr_q;
    end

endmodule
